// File: rtl/audio_i2s_pkg.sv
// Shared defaults, FSM state encoding and sample-pair type for the I2S transmitter.
package audio_i2s_pkg;

    localparam int DEF_DATA_W     = 24;
    localparam int DEF_SLOT_W     = 32;
    localparam int DEF_MCLK_DIV   = 4;
    localparam int DEF_SETTLE_CYC = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } i2s_state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] left;
        logic [DEF_DATA_W-1:0] right;
    } sample_pair_t;

endpackage

// File: rtl/i2s_lock_sync.sv
// Brings the PLL lock into the refclk domain and times how long it has stayed
// asserted while the FSM is settling.
module i2s_lock_sync
    import audio_i2s_pkg::*;
#(
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic settle_en,
    output logic lock_s,
    output logic lock_stable
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic             lock_meta;
    logic [CNT_W-1:0] settle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Any lock dropout restarts the settle window from zero.
    always_ff @(posedge clk) begin
        if (rst || !settle_en || !lock_s) begin
            settle_cnt <= '0;
        end else begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    assign lock_stable = settle_en && lock_s && (settle_cnt == CNT_W'(SETTLE_CYC - 1));

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: derives BCLK/LRCLK from refclk and shifts out one stereo pair
// per frame, repeating the last pair when the source falls behind.
//
// state  | meaning
// IDLE   | PLL not locked; everything quiet
// SETTLE | lock seen, waiting for it to stay up for SETTLE_CYC cycles
// RUN    | clocks and data running
module i2s_tx_serializer
    import audio_i2s_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SLOT_W     = DEF_SLOT_W,
    parameter int MCLK_DIV   = DEF_MCLK_DIV,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_dout,
    output logic              underrun,
    output logic              running
);

    localparam int FRM_W = 2 * SLOT_W;
    localparam int DIV_W = $clog2(MCLK_DIV);
    localparam int BIT_W = $clog2(FRM_W);

    i2s_state_e       state;
    logic             lock_s;
    logic             lock_stable;
    logic             settle_en;
    logic             run_st;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             div_wrap;
    logic             frame_start;
    logic             accept;
    logic             hold_full;
    sample_pair_t     hold_pair;
    sample_pair_t     frame_pair;
    sample_pair_t     frame_src;
    logic [FRM_W-1:0] frame_img;
    logic [FRM_W-1:0] shift_reg;
    logic             bclk_d;
    logic             lrclk_d;
    logic             dout_d;

    assign settle_en = (state == SETTLE);

    i2s_lock_sync #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_lock_sync (
        .clk         (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .settle_en   (settle_en),
        .lock_s      (lock_s),
        .lock_stable (lock_stable)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (lock_s) state <= SETTLE;
                SETTLE: begin
                    if (!lock_s)          state <= IDLE;
                    else if (lock_stable) state <= RUN;
                end
                RUN:     if (!lock_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign run_st      = (state == RUN);
    assign running     = run_st;
    assign s_ready     = run_st && !hold_full;
    assign accept      = s_valid && s_ready;
    assign div_wrap    = (div_cnt == DIV_W'(MCLK_DIV - 1));
    assign frame_start = run_st && (div_cnt == '0) && (bit_cnt == '0);
    assign underrun    = frame_start && !hold_full;

    // Frame image, MSB first: one idle bit after each LRCLK edge, then the
    // sample, then zero padding to the end of the slot.
    always_comb begin
        frame_src = hold_full ? hold_pair : frame_pair;
        frame_img = '0;
        frame_img[FRM_W-2 -: DATA_W]  = frame_src.left;
        frame_img[SLOT_W-2 -: DATA_W] = frame_src.right;
    end

    always_ff @(posedge refclk) begin
        if (rst || !run_st) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            hold_full <= 1'b0;
            hold_pair <= '0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bit_cnt <= (bit_cnt == BIT_W'(FRM_W - 1)) ? '0 : bit_cnt + 1'b1;
            end

            if (frame_start) begin
                shift_reg <= frame_img;
            end else if (div_wrap) begin
                shift_reg <= {shift_reg[FRM_W-2:0], 1'b0};
            end

            // ready is low while full, so an accept never collides with a drain
            if (accept) begin
                hold_pair <= '{left: s_left, right: s_right};
                hold_full <= 1'b1;
            end else if (frame_start && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

    // Kept across relock so a restart with no fresh sample repeats the last pair.
    always_ff @(posedge refclk) begin
        if (rst) begin
            frame_pair <= '0;
        end else if (frame_start && hold_full) begin
            frame_pair <= hold_pair;
        end
    end

    assign bclk_d  = (div_cnt >= DIV_W'(MCLK_DIV / 2));
    assign lrclk_d = (bit_cnt >= BIT_W'(SLOT_W));
    assign dout_d  = shift_reg[FRM_W-1];

    always_ff @(posedge refclk) begin
        if (rst || !run_st) begin
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_dout  <= 1'b0;
        end else begin
            i2s_bclk  <= bclk_d;
            i2s_lrclk <= lrclk_d;
            i2s_dout  <= dout_d;
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench: stimulus queues expected frames and underrun flags; monitors
// decode the serial stream and frame starts independently.
`timescale 1ns/1ps
module tb_i2s_tx_serializer;
    import audio_i2s_pkg::*;

    localparam int FRAME_CYC = 256;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
    } frame_t;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b0;
    logic        s_valid = 1'b0;
    logic [23:0] s_left = '0;
    logic [23:0] s_right = '0;
    logic        s_ready, i2s_bclk, i2s_lrclk, i2s_dout, underrun, running;

    int     n_checks = 0;
    int     n_fail = 0;
    int     rcyc = -1;
    frame_t data_q[$];
    bit     under_q[$];

    i2s_tx_serializer dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_left     (s_left),
        .s_right    (s_right),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_dout   (i2s_dout),
        .underrun   (underrun),
        .running    (running)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_checks++;
        if (val < lo || val > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Frame-start monitor: rcyc counts RUN cycles, a frame starts every FRAME_CYC.
    always @(negedge refclk) begin
        if (!running) begin
            rcyc = -1;
            check("ready_not_running", s_ready, 0);
            check("underrun_not_running", underrun, 0);
        end else begin
            rcyc++;
            if (rcyc % FRAME_CYC == 0) begin
                if (under_q.size() == 0) fail_now("underrun_queue_empty");
                else check("underrun_frame_start", underrun, under_q.pop_front());
            end else begin
                check("underrun_mid_frame", underrun, 0);
            end
        end
    end

    // Serial monitor: sample dout/lrclk on each BCLK rising edge.
    int   bitpos = -1;
    int   since_rise = 0;
    bit   have_rise = 0;
    logic bclk_q = 1'b0;
    logic dout_q = 1'b0;
    logic frm [64];

    always @(negedge refclk) begin : mon_serial
        logic [23:0] gl, gr;
        logic        pad;
        frame_t      e;
        if (!running) begin
            bitpos = -1;
            have_rise = 0;
            since_rise = 0;
        end else begin
            since_rise++;
            if (i2s_bclk && !bclk_q) begin
                if (have_rise) check("bclk_period", since_rise, 4);
                have_rise = 1;
                since_rise = 0;
                check("dout_stable_at_rise", i2s_dout, dout_q);
                bitpos = (bitpos + 1) % 64;
                check("lrclk_slot", i2s_lrclk, (bitpos >= 32) ? 1 : 0);
                frm[bitpos] = i2s_dout;
                if (bitpos == 63) begin
                    gl = '0;
                    gr = '0;
                    pad = 1'b0;
                    for (int i = 0; i < 64; i++) begin
                        if (i >= 1 && i <= 24)       gl = {gl[22:0], frm[i]};
                        else if (i >= 33 && i <= 56) gr = {gr[22:0], frm[i]};
                        else                         pad = pad | frm[i];
                    end
                    if (data_q.size() == 0) begin
                        fail_now("frame_queue_empty");
                    end else begin
                        e = data_q.pop_front();
                        check("frame_left", gl, e.l);
                        check("frame_right", gr, e.r);
                        check("frame_padding", pad, 0);
                    end
                end
            end
        end
        bclk_q = i2s_bclk;
        dout_q = i2s_dout;
    end

    task automatic step();
        @(negedge refclk);
        #1;
    endtask

    task automatic wait_rcyc(input int n);
        for (int i = 0; i < 5000; i++) begin
            if (rcyc == n) return;
            step();
        end
        fail_now("wait_rcyc_timeout");
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r, output int acc);
        acc = -1;
        s_valid = 1'b1;
        s_left = l;
        s_right = r;
        for (int i = 0; i < 600; i++) begin
            if (s_ready) begin
                acc = rcyc;
                step();
                s_valid = 1'b0;
                check("ready_low_after_accept", s_ready, 0);
                return;
            end
            step();
        end
        s_valid = 1'b0;
        fail_now("send_timeout");
    endtask

    task automatic wait_running(input logic val, output int n);
        n = 0;
        while (running !== val && n < 400) begin
            step();
            n++;
        end
    endtask

    initial begin
        int acc;
        int lat;
        repeat (5) step();
        check("reset_outputs", {s_ready, i2s_bclk, i2s_lrclk, i2s_dout, underrun, running}, 0);
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            check("unlocked_outputs", {s_ready, i2s_bclk, i2s_lrclk, i2s_dout, underrun, running}, 0);
        end

        // frame 1: zeros, underrun
        under_q.push_back(1'b1);
        data_q.push_back('{l: 24'h000000, r: 24'h000000});
        pll_locked = 1'b1;
        wait_running(1'b1, lat);
        check_range("lock_to_running", lat, 257, 259);
        check("ready_first_run_cycle", s_ready, 1);

        // frame 2 carries A, frame 3 repeats it with underrun
        wait_rcyc(50);
        under_q.push_back(1'b0);
        data_q.push_back('{l: 24'hABCDEF, r: 24'h123456});
        send(24'hABCDEF, 24'h123456, acc);
        check("accept_cycle_a", acc, 50);
        wait_rcyc(300);
        under_q.push_back(1'b1);
        data_q.push_back('{l: 24'hABCDEF, r: 24'h123456});

        // streaming: one accept per frame, frames 4..8
        wait_rcyc(600);
        for (int i = 0; i < 5; i++) begin
            under_q.push_back(1'b0);
            data_q.push_back('{l: 24'h800001 + 24'(i), r: 24'h000100 + 24'(i)});
            send(24'h800001 + 24'(i), 24'h000100 + 24'(i), acc);
            check("accept_cycle_stream", acc, (i == 0) ? 600 : 768 + 256 * (i - 1) + 1);
        end
        under_q.push_back(1'b1);

        // sample parked in hold during frame 9, then lock lost mid-right-slot
        wait_rcyc(2100);
        send(24'h5A5A5A, 24'hA5A5A5, acc);
        check("accept_cycle_z", acc, 2100);
        wait_rcyc(2228);
        pll_locked = 1'b0;
        wait_running(1'b0, lat);
        check_range("unlock_to_idle", lat, 1, 3);
        step();
        check("outputs_after_unlock", {i2s_bclk, i2s_lrclk, i2s_dout, underrun, s_ready}, 0);

        // relock: hold must have emptied, so first frame underruns and ready is high
        repeat (20) step();
        under_q.push_back(1'b1);
        pll_locked = 1'b1;
        wait_running(1'b1, lat);
        check_range("relock_to_running", lat, 257, 259);
        check("relock_hold_empty", s_ready, 1);
        for (int i = 0; i < 100; i++) begin
            step();
            check("relock_lrclk_low", i2s_lrclk, 0);
            if (rcyc == 3) check("relock_first_bclk_rise", i2s_bclk, 1);
        end

        check("frames_drained", data_q.size(), 0);
        check("underruns_drained", under_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
